// File: rtl/demux_sched_pkg.sv
// rtl/demux_sched_pkg.sv - shared types, constants and helpers for the 4-way burst scheduler
package demux_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;

  function automatic logic [CH_NUM-1:0] onehot4(input logic [SEL_W-1:0] s);
    onehot4 = 4'b0001 << s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first set mask bit scanning upward from ptr with wraparound
module rr_pick
  import demux_sched_pkg::*;
(
  input  logic [SEL_W-1:0]  ptr,
  input  logic [CH_NUM-1:0] mask,
  output logic [SEL_W-1:0]  pick,
  output logic              any
);

  logic [SEL_W-1:0] idx;

  // Scan from the far end so the closest enabled channel to ptr wins last.
  always_comb begin
    pick = ptr;
    any  = 1'b0;
    idx  = ptr;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (mask[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux4_burst_scheduler.sv
// rtl/demux4_burst_scheduler.sv - routes one word stream to four channels, BURST words per channel
module demux4_burst_scheduler
  import demux_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] ch_en,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [CH_NUM-1:0] out_valid,
  input  logic [CH_NUM-1:0] out_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              busy
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [SEL_W-1:0] target;
  logic             any_en;

  rr_pick u_rr_pick (
    .ptr  (ptr_q),
    .mask (ch_en),
    .pick (target),
    .any  (any_en)
  );

  assign busy      = (state_q == HOLD);
  assign in_ready  = rst_n && !busy && any_en;
  assign out_valid = onehot4(sel_q) & {CH_NUM{busy}};
  assign out_data  = out_data_q;
  assign sel       = sel_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    beat_cnt_d = beat_cnt_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          out_data_d = in_data;
          sel_d      = target;
          state_d    = HOLD;
          if (target != ptr_q) begin
            beat_cnt_d = 8'd0;
            ptr_d      = target;
          end
        end
      end
      HOLD: begin
        // A channel disabled mid-hold still gets its word but loses the rest of its burst.
        if (out_ready[sel_q]) begin
          state_d = IDLE;
          if (beat_cnt_q == LAST_BEAT || !ch_en[sel_q]) begin
            beat_cnt_d = 8'd0;
            ptr_d      = sel_q + 2'd1;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      beat_cnt_q <= 8'd0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      beat_cnt_q <= beat_cnt_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_demux4_burst_scheduler.sv
// tb/tb_demux4_burst_scheduler.sv - self-checking bench for demux4_burst_scheduler and rr_pick
module tb_demux4_burst_scheduler;

  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic             clk;
  logic             rst_n;
  logic [3:0]       ch_en;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [1:0]       sel;
  logic             busy;

  logic [1:0] rp_ptr;
  logic [3:0] rp_mask;
  logic [1:0] rp_pick;
  logic       rp_any;

  int checks   = 0;
  int failures = 0;

  int m_ptr  = 0;
  int m_beat = 0;

  demux4_burst_scheduler #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  rr_pick u_rr (
    .ptr  (rp_ptr),
    .mask (rp_mask),
    .pick (rp_pick),
    .any  (rp_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  function automatic int m_target(input logic [3:0] en);
    for (int k = 0; k < 4; k++) begin
      if (en[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  // One word: offer it, let it sit `hold` refused cycles, then complete it.
  task automatic xfer(input logic [7:0] d, input int hold, input logic [3:0] en_hold, input int exp_ch);
    int tgt;
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 4'h0;
    #1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    tgt = m_target(ch_en);
    @(posedge clk);
    if (tgt != m_ptr) begin
      m_beat = 0;
      m_ptr  = tgt;
    end
    #1;
    in_data   = 8'($urandom);
    ch_en     = en_hold;
    out_ready = (hold > 0) ? ~oh(tgt) : 4'hF;
    @(negedge clk);
    chk("out_valid_hold", 32'(out_valid), 32'(oh(tgt)));
    chk("out_data_hold", 32'(out_data), 32'(d));
    chk("sel_hold", 32'(sel), 32'(tgt));
    chk("busy_hold", 32'(busy), 32'd1);
    chk("in_ready_hold", 32'(in_ready), 32'd0);
    if (exp_ch >= 0) chk("sel_route", 32'(sel), 32'(exp_ch));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (i == hold - 1) out_ready = 4'hF;
      @(negedge clk);
      chk("out_valid_stall", 32'(out_valid), 32'(oh(tgt)));
      chk("out_data_stall", 32'(out_data), 32'(d));
      chk("in_ready_stall", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    if (m_beat == BURST - 1 || !ch_en[tgt]) begin
      m_beat = 0;
      m_ptr  = (tgt + 1) % 4;
    end else begin
      m_beat = m_beat + 1;
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    @(negedge clk);
    chk("out_valid_done", 32'(out_valid), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int exp_pick;
    logic [3:0] en;
    logic [3:0] en_h;
    int seq_1010 [8] = '{1, 1, 1, 1, 3, 3, 3, 3};

    rst_n     = 1'b1;
    ch_en     = 4'hF;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    rp_ptr    = '0;
    rp_mask   = '0;
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    for (int p = 0; p < 4; p++) begin
      for (int m = 0; m < 16; m++) begin
        rp_ptr  = 2'(p);
        rp_mask = 4'(m);
        #1;
        exp_pick = -1;
        for (int k = 3; k >= 0; k--) if (rp_mask[(p + k) % 4]) exp_pick = (p + k) % 4;
        chk("rr_any", 32'(rp_any), (exp_pick >= 0) ? 32'd1 : 32'd0);
        if (exp_pick >= 0) chk("rr_pick", 32'(rp_pick), 32'(exp_pick));
      end
    end

    @(posedge clk);
    #1 rst_n = 1'b1;

    ch_en    = 4'b0100;
    in_data  = 8'h5A;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", 32'(out_valid), 32'b0100);
    chk("pre_rst_out_data", 32'(out_data), 32'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ptr  = 0;
    m_beat = 0;
    @(negedge clk);

    ch_en = 4'hF;
    for (int i = 0; i < 16; i++) xfer(8'(i), 0, 4'hF, i / 4);

    ch_en = 4'b1010;
    for (int i = 0; i < 8; i++) xfer(8'($urandom), 0, 4'b1010, seq_1010[i]);

    ch_en = 4'b0010;
    xfer(8'h33, 5, 4'b0010, 1);

    ch_en = 4'hF;
    xfer(8'h44, 0, 4'b1101, 1);
    xfer(8'h45, 0, 4'b1101, 2);

    ch_en    = 4'h0;
    in_valid = 1'b1;
    in_data  = 8'h66;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dis_in_ready", 32'(in_ready), 32'd0);
      chk("dis_out_valid", 32'(out_valid), 32'd0);
    end
    ch_en = 4'b0100;
    xfer(8'h77, 0, 4'b0100, 2);

    for (int n = 0; n < 200; n++) begin
      en    = 4'($urandom_range(1, 15));
      ch_en = en;
      en_h  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : en;
      xfer(8'($urandom), int'($urandom_range(0, 3)), en_h, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux4_burst_scheduler.md
Name: demux4_burst_scheduler

Overview:
- Sequencing controller for the team's 1-to-4 demultiplexer.
- Accepts a single valid/ready word stream and routes words to four consumer channels in round-robin order, BURST words per channel.
- Skips channels whose enable bit is low. Drives the demux select lines and the one-hot per-channel valid.
- Sits between a single producer (e.g. UART/serial deframer) and four downstream sinks.

Parameters:
WIDTH, 8, data word width in bits
BURST, 4, words sent to one channel before the pointer advances (legal 1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ch_en  input  4  per-channel enable mask; bit i enables channel i
in_data  input  WIDTH  producer data word
in_valid  input  1  producer word valid
in_ready  output  1  scheduler can accept a word this cycle
out_data  output  WIDTH  registered word, shared by all channels
out_valid  output  4  one-hot valid; bit sel is set while a word is held
out_ready  input  4  per-channel consumer ready
sel  output  2  current channel select (s1=sel[1], s0=sel[0]) for the demux
busy  output  1  high while a word is held (HOLD state)

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous, active-low.
- Reset values (asynchronous on rst_n low): state=IDLE, ptr=0, sel=0, beat_cnt=0, out_data=0, out_valid=0, busy=0. in_ready is combinational, so it is 0 during reset.
- States: IDLE, HOLD.
- IDLE behaviour:
  - in_ready = (ch_en != 0).
  - Target channel = first enabled channel scanning ptr, ptr+1, ... mod 4, wrapping 3->0.
  - On in_valid & in_ready: out_data <= in_data; sel <= target; if target != ptr, beat_cnt <= 0 and ptr <= target; state <= HOLD.
- HOLD behaviour:
  - in_ready = 0; busy = 1.
  - out_valid = one-hot(sel), i.e. the demux output with x=1 and select=sel.
  - out_data and sel are stable for the whole of HOLD.
- HOLD exit, on out_ready[sel]:
  - The transfer completes; state <= IDLE; out_valid clears next cycle.
  - If beat_cnt == BURST-1: beat_cnt <= 0 and ptr <= (sel+1) mod 4.
  - Otherwise beat_cnt <= beat_cnt+1.
- Latency and throughput:
  - Accepted word appears on out_data/out_valid 1 cycle after the in_valid&in_ready edge.
  - Maximum throughput is 1 word per 2 cycles; no back-to-back acceptance.
- out_ready on non-selected channels is ignored.
- ch_en == 0: no word is accepted (in_ready=0). ptr and beat_cnt hold.
- ch_en bit of the held channel drops during HOLD:
  - The held word still completes to that channel; words are never dropped or redirected.
  - Its burst ends early: on completion beat_cnt <= 0 and ptr <= sel+1.
- ch_en changes take effect at the next IDLE selection only.
- The target is chosen from ch_en and ptr as sampled in the accepting cycle.
- Reset mid-HOLD: the held word is discarded and all outputs clear immediately.
- Simultaneous in_valid and out_ready in HOLD: only the out_ready completion is acted on; the producer waits for IDLE.
- beat_cnt width is 8 bits; BURST=1 degenerates to pure word round-robin.

Decomposition:
- Shared package demux_sched_pkg:
  - state enum {IDLE, HOLD}
  - constant CH_NUM=4, SEL_W=2
  - function onehot4(sel)
- One natural sub-module: rr_pick.
  - Combinational. Inputs: ptr[1:0], mask[3:0]. Outputs: pick[1:0], any.
  - Unit-tested separately.
- out_valid decode reuses the team's existing 1-to-4 dataflow demux, with x=busy and select=sel.

Test Plan:
- Reset with rst_n=0 mid-HOLD (word 0x5A held on ch2) -> out_valid=0000, sel=0, busy=0, out_data=0 in the same cycle; after release ptr=0.
- ch_en=1111, BURST=4, 16 words 0x00..0x0F, all out_ready=1 -> 0x00-0x03 on ch0, 0x04-0x07 on ch1, 0x08-0x0B on ch2, 0x0C-0x0F on ch3; each out_valid pulse is 1 cycle, one word per 2 cycles.
- ch_en=1010, BURST=2, 6 words -> channels 1,1,3,3,1,1; out_valid never 0001 or 0100.
- Word 0x33 held on ch1, out_ready[1]=0 for 5 cycles and out_ready[0]=1 -> out_valid=0010 and out_data=0x33 stable for 5 cycles, in_ready=0; completes only when out_ready[1]=1.
- ch_en[1] cleared during HOLD of the 2nd beat on ch1 (BURST=4) -> word delivered to ch1, next word goes to ch2 with beat_cnt=0.
- ch_en=0000 with in_valid=1 for 10 cycles -> in_ready=0 and no out_valid; then ch_en=0100 -> next word routed to ch2 with sel=2.
